// File: rtl/dropout_mask_gen.sv
// dropout_mask_gen: produces one 8-lane keep mask per request, one lane per
// clock, from a 32-bit Galois LFSR compared against a captured drop rate.
// Optional statistics outputs are enabled with `define DROPOUT_MASK_STATS_EN.
module dropout_mask_gen #(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
  input  logic [7:0]  rate,
  input  logic        req,
  output logic        busy,
  output logic [7:0]  mask,
  output logic        mask_valid,
  input  logic        mask_ready
`ifdef DROPOUT_MASK_STATS_EN
  ,
  output logic [3:0]  drop_count,
  output logic [31:0] total_dropped
`endif
);

  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_lfsr;
  logic [31:0] w_lfsr_step;
  logic [2:0]  r_lane;
  logic [7:0]  r_rate_q;
  logic [7:0]  r_mask;
  logic [7:0]  w_mask_upd;
  logic        w_handshake;
  logic        w_start;
  logic        w_last_lane;

  // LFSR step, current-lane update and handshake/start decode
  always_comb begin
    w_lfsr_step        = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : '0);
    w_mask_upd         = r_mask;
    w_mask_upd[r_lane] = (w_lfsr_step[7:0] >= r_rate_q);
    w_handshake        = (r_state == VALID) && mask_ready;
    w_start            = req && ((r_state == IDLE) || w_handshake);
    w_last_lane        = (r_state == GEN) && (r_lane == 3'd7);
  end

  // Next-state decode; seed_load aborts to IDLE from any state
  always_comb begin
    w_state_nxt = r_state;
    if (seed_load) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (req) w_state_nxt = GEN;
        GEN:     if (r_lane == 3'd7) w_state_nxt = VALID;
        VALID:   if (mask_ready) w_state_nxt = req ? GEN : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // LFSR, captured rate, lane counter and mask datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr   <= SEED;
      r_rate_q <= '0;
      r_lane   <= '0;
      r_mask   <= '0;
    end else if (seed_load) begin
      r_lfsr <= (seed_in == '0) ? SEED : seed_in;
      r_lane <= '0;
      r_mask <= '0;
    end else if (w_start) begin
      r_rate_q <= rate;
      r_lane   <= '0;
      r_mask   <= '0;
    end else if (r_state == GEN) begin
      r_lfsr <= w_lfsr_step;
      r_mask <= w_mask_upd;
      r_lane <= r_lane + 3'd1;
    end
  end

  assign busy       = (r_state == GEN);
  assign mask_valid = (r_state == VALID);
  assign mask       = r_mask;

`ifdef DROPOUT_MASK_STATS_EN
  function automatic logic [3:0] zero_count(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + {3'b000, ~m[i]};
    return c;
  endfunction

  logic [3:0]  r_drop_count;
  logic [31:0] r_total_dropped;
  logic [32:0] w_total_sum;

  // Saturating accumulator input
  always_comb begin
    w_total_sum = {1'b0, r_total_dropped} + {29'd0, r_drop_count};
  end

  // drop_count tracks the held mask; total_dropped survives seed_load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count    <= '0;
      r_total_dropped <= '0;
    end else if (seed_load) begin
      r_drop_count <= '0;
    end else begin
      if (w_last_lane)      r_drop_count <= zero_count(w_mask_upd);
      else if (w_handshake) r_drop_count <= '0;
      if (w_handshake)
        r_total_dropped <= w_total_sum[32] ? '1 : w_total_sum[31:0];
    end
  end

  assign drop_count    = r_drop_count;
  assign total_dropped = r_total_dropped;
`else
  logic w_unused;
  assign w_unused = w_last_lane;
`endif

endmodule

// File: tb/tb_dropout_mask_gen.sv
// Scoreboard bench for dropout_mask_gen: a reference LFSR model predicts each
// mask when a request is accepted; a negedge monitor pops and compares at
// every handshake.
module tb_dropout_mask_gen;

  localparam logic [31:0] SEED_DEF = 32'hACE1_2468;
  localparam logic [31:0] POLY     = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        reset;
  logic        seed_load;
  logic [31:0] seed_in;
  logic [7:0]  rate;
  logic        req;
  logic        busy;
  logic [7:0]  mask;
  logic        mask_valid;
  logic        mask_ready;
`ifdef DROPOUT_MASK_STATS_EN
  logic [3:0]  drop_count;
  logic [31:0] total_dropped;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  sb[$];
  logic [31:0] m_lfsr;
  logic [31:0] m_total;
  int unsigned obs_drop;

  always #5 clk = ~clk;

  dropout_mask_gen #(.SEED(SEED_DEF)) dut (
    .clk(clk),
    .reset(reset),
    .seed_load(seed_load),
    .seed_in(seed_in),
    .rate(rate),
    .req(req),
    .busy(busy),
    .mask(mask),
    .mask_valid(mask_valid),
    .mask_ready(mask_ready)
`ifdef DROPOUT_MASK_STATS_EN
    ,
    .drop_count(drop_count),
    .total_dropped(total_dropped)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [3:0] zeros(input logic [7:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) if (!m[i]) c = c + 4'd1;
    return c;
  endfunction

  // Predict the next mask from the reference LFSR and queue it.
  task automatic push_exp(input logic [7:0] r);
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      m_lfsr = lstep(m_lfsr);
      e[i]   = (m_lfsr[7:0] >= r);
    end
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!mask_valid && k < 20) begin
      tick;
      k++;
    end
    check(tag, 32'(mask_valid), 32'd1);
  endtask

  // One request from IDLE with mask_ready held high.
  task automatic run_one(input logic [7:0] r);
    rate = r;
    req  = 1'b1;
    push_exp(r);
    tick;
    req = 1'b0;
    wait_valid("run_valid");
    tick;
  endtask

  // n back-to-back masks with req held high across each handshake.
  task automatic run_b2b(input int n, input logic [7:0] r);
    rate = r;
    req  = 1'b1;
    for (int k = 0; k < n; k++) begin
      push_exp(r);
      tick;
      wait_valid("b2b_valid");
    end
    req = 1'b0;
    tick;
  endtask

  // Monitor: compare each mask the cycle before it is accepted
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (!reset && mask_valid && mask_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("mask", 32'(mask), 32'(e));
        obs_drop += 32'(zeros(mask));
`ifdef DROPOUT_MASK_STATS_EN
        check("drop_count", 32'(drop_count), 32'(zeros(e)));
        check("total_dropped", total_dropped, m_total);
        if (m_total > (32'hFFFF_FFFF - 32'(zeros(e)))) m_total = 32'hFFFF_FFFF;
        else m_total = m_total + 32'(zeros(e));
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    reset = 1'b1; seed_load = 1'b0; seed_in = '0; rate = '0; req = 1'b0; mask_ready = 1'b1;
    m_lfsr = SEED_DEF; m_total = '0; obs_drop = 0;
    repeat (3) tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(mask_valid), 32'd0);
    check("rst_mask", 32'(mask), 32'd0);
    reset = 1'b0;
    tick;

    // Latency and busy width at rate 0
    rate = 8'd0; req = 1'b1; push_exp(8'd0);
    tick;
    req = 1'b0;
    check("lat_busy0", 32'(busy), 32'd1);
    check("lat_valid0", 32'(mask_valid), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick;
      check("lat_busy", 32'(busy), 32'(i < 8));
      check("lat_valid", 32'(mask_valid), 32'(i == 8));
    end
    check("rate0_mask", 32'(mask), 32'h0000_00FF);
    tick;
    check("post_hs_valid", 32'(mask_valid), 32'd0);
    check("post_hs_busy", 32'(busy), 32'd0);

    // Assorted rates
    run_one(8'd255);
    run_one(8'd128);
    run_one(8'd1);
    run_one(8'd64);
    run_one(8'($urandom_range(0, 255)));

    // Back-pressure: held mask while rate and req wiggle
    mask_ready = 1'b0;
    rate = 8'd77; req = 1'b1; push_exp(8'd77);
    tick;
    req = 1'b0;
    wait_valid("bp_wait");
    e = sb[0];
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", 32'(mask_valid), 32'd1);
      check("bp_mask", 32'(mask), 32'(e));
      check("bp_busy", 32'(busy), 32'd0);
      rate = 8'($urandom_range(0, 255));
      req  = (i % 2 == 1);
      tick;
    end
    mask_ready = 1'b1; req = 1'b1; rate = 8'd9; push_exp(8'd9);
    tick;
    check("b2b_busy", 32'(busy), 32'd1);
    req = 1'b0;
    wait_valid("bp_next");
    tick;

    // Determinism across seed loads
    for (int rep = 0; rep < 2; rep++) begin
      seed_load = 1'b1; seed_in = 32'h1234_5678;
      tick;
      seed_load = 1'b0; m_lfsr = 32'h1234_5678;
      check("sl_valid", 32'(mask_valid), 32'd0);
      check("sl_mask", 32'(mask), 32'd0);
      for (int k = 0; k < 4; k++) run_one(8'd128);
    end
    seed_load = 1'b1; seed_in = 32'h0;
    tick;
    seed_load = 1'b0; m_lfsr = SEED_DEF;
    for (int k = 0; k < 4; k++) run_one(8'd128);

    // Abort mid-GEN with seed_load at lane 3
    rate = 8'd128; req = 1'b1; push_exp(8'd128);
    tick;
    req = 1'b0;
    repeat (3) tick;
    check("abort_pre_busy", 32'(busy), 32'd1);
    seed_load = 1'b1; seed_in = 32'hDEAD_BEEF;
    tick;
    seed_load = 1'b0;
    void'(sb.pop_back());
    m_lfsr = 32'hDEAD_BEEF;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(mask_valid), 32'd0);
    check("abort_mask", 32'(mask), 32'd0);
    run_one(8'd128);

    // Asynchronous reset mid-GEN
    rate = 8'd128; req = 1'b1; push_exp(8'd128);
    tick;
    req = 1'b0;
    repeat (2) tick;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mask", 32'(mask), 32'd0);
    #1;
    reset = 1'b0;
    void'(sb.pop_back());
    m_lfsr = SEED_DEF; m_total = '0;
    tick;
    run_one(8'd128);

    // Reset while a mask is held
    mask_ready = 1'b0;
    rate = 8'd200; req = 1'b1; push_exp(8'd200);
    tick;
    req = 1'b0;
    wait_valid("rstv_wait");
    reset = 1'b1;
    #1;
    check("rstv_valid", 32'(mask_valid), 32'd0);
    check("rstv_mask", 32'(mask), 32'd0);
    #1;
    reset = 1'b0;
    void'(sb.pop_back());
    m_lfsr = SEED_DEF; m_total = '0;
    mask_ready = 1'b1;
    tick;

    // Drop statistics over back-to-back streams
    obs_drop = 0;
    run_b2b(1024, 8'd128);
    check("drop_in_range", 32'(obs_drop >= 3900 && obs_drop <= 4300), 32'd1);
    obs_drop = 0;
    run_b2b(1024, 8'd0);
    check("drop_rate0", obs_drop, 32'd0);

`ifdef DROPOUT_MASK_STATS_EN
    run_b2b(100, 8'd100);
    check("total_run", total_dropped, m_total);
    force dut.r_total_dropped = 32'hFFFF_FFFC;
    #1;
    release dut.r_total_dropped;
    m_total = 32'hFFFF_FFFC;
    run_one(8'd255);
    run_one(8'd255);
    check("total_sat", total_dropped, m_total);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
